adder_256_sched: RTL and testbench
==================================

Name: adder_256_sched

Overview:
- Shares one chunked 256-bit add datapath between NREQ requesters.
- Round-robin arbitration on valid/ready request ports.
- Each accepted operation runs as CHUNK_W-bit slices, least-significant first, with the carry rippled through a register.
- Returns sum, carry-out and requester id on a single valid/ready response port. Sits in front of the 256-bit add path, replacing direct operand drive with a handshake.

Parameters:
- DATA_W, 256, operand/sum width.
- CHUNK_W, 64, bits added per cycle; must divide DATA_W.
- NREQ, 2, number of requesters (2..8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  request present, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero).
- req_a  in  NREQ*DATA_W  operand A; requester i occupies slice i.
- req_b  in  NREQ*DATA_W  operand B; requester i occupies slice i.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_sum  out  DATA_W  A+B+cin modulo 2^DATA_W.
- rsp_cout  out  1  carry out of bit DATA_W-1.
- rsp_id  out  clog2(NREQ)  index of requester served.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- NCHUNK = DATA_W/CHUNK_W.
- States: IDLE, ADD, RESP.
- Reset, applied in any state including mid-ADD or RESP:
  - state=IDLE; rr_ptr=0; chunk counter=0; carry reg=0.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, req_ready=0.
  - Any in-flight operation is discarded. No response is ever produced for it.
- IDLE:
  - grant = first requester with req_valid=1, searching from rr_ptr upward with wrap.
  - req_ready[grant]=1 combinationally; req_ready=0 everywhere when no valid or not IDLE.
  - On handshake: latch A, B, cin and id; carry reg=cin; cnt=0; rr_ptr=(grant+1) mod NREQ; go to ADD.
- ADD, one cycle per chunk:
  - sum[cnt*CHUNK_W +: CHUNK_W] = A_chunk + B_chunk + carry reg.
  - carry reg = carry out of that chunk; cnt++.
  - After chunk NCHUNK-1: rsp_cout = final carry; go to RESP.
- RESP:
  - rsp_valid=1; rsp_sum, rsp_cout and rsp_id held stable.
  - On rsp_valid&rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: handshake in cycle T → rsp_valid high from cycle T+NCHUNK+1. Default is T+5.
- Throughput: at most one op per NCHUNK+2 cycles when rsp_ready is held high.
- Request inputs are ignored outside IDLE. A requester that drops valid without a handshake is never served.
- Simultaneous requests are served in round-robin order. No requester waits more than NREQ-1 grants.
- rsp_* outputs keep their last value after the response handshake until the next RESP.

Decomposition:
- Package adder_sched_pkg:
  - state enum {IDLE, ADD, RESP};
  - function clog2;
  - localparam NCHUNK derivation helper.
- Sub-module rr_arbiter: NREQ-wide, combinational grant from valid and rr_ptr, plus grant index output.
- The chunk adder stays inline (a single CHUNK_W+1-bit add).

Test Plan:
- Req0 A=0xff, B=0xff, cin=1:
  - rsp_sum=0x1ff, rsp_cout=0, rsp_id=0;
  - rsp_valid exactly 5 cycles after the handshake.
- Req1 A=all-ones, B=0, cin=1 → rsp_sum=0, rsp_cout=1. Checks carry ripple across all 4 chunks.
- Req0 A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1, cin=0 → rsp_sum=2^64 (bit 64 set only), rsp_cout=0. Checks chunk-boundary carry.
- Both requesters hold valid for 4 ops, rr_ptr=0 after reset → grant order 0,1,0,1; req_ready never high for both at once.
- Response backpressure:
  - rsp_ready=0 for 10 cycles in RESP → rsp_* stable, req_ready=0 throughout, busy=1;
  - rsp_ready=1 → IDLE next cycle.
- Reset mid-operation:
  - rst asserted during the 2nd ADD cycle → next cycle IDLE, busy=0, rsp_valid=0, no response;
  - a following request computes correctly.

Source files
------------

// File: rtl/adder_256_sched_pkg.sv
// adder_sched_pkg: FSM state type and width/chunk-count helpers for adder_256_sched
package adder_sched_pkg;
  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return r;
  endfunction
  function automatic int nchunk(input int dw, input int cw);
    return dw / cw;
  endfunction
endpackage

// File: rtl/adder_256_sched_rr_arbiter.sv
// rr_arbiter: round-robin grant from i_valid starting at i_ptr; o_grant one-hot, o_idx its index, o_any any valid
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW = 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_valid[(int'(i_ptr) + k) % NREQ]) begin
        o_idx = IW'((int'(i_ptr) + k) % NREQ);
        o_any = 1'b1;
      end
  end
  assign o_grant = o_any ? NREQ'(1) << o_idx : '0;
endmodule

// File: rtl/adder_256_sched.sv
// adder_256_sched: round-robin shared chunked DATA_W adder; req_* valid/ready in, rsp_* valid/ready out, busy
module adder_256_sched
  import adder_sched_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int CHUNK_W = 64,
  parameter int NREQ = 2,
  localparam int IW = clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_cin,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_cout,
  output logic [IW-1:0]          rsp_id,
  output logic                   busy
);
  localparam int NCHUNK = nchunk(DATA_W, CHUNK_W);
  localparam int CNTW = NCHUNK > 1 ? clog2(NCHUNK) : 1;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_op_id, r_id, w_idx;
  logic [NREQ-1:0] w_grant;
  logic w_any, w_take, w_last;
  logic [CNTW-1:0] r_cnt;
  logic r_carry, r_cout;
  logic [DATA_W-1:0] r_a, r_b, r_acc, r_sum, w_acc;
  logic [CHUNK_W:0] w_chunk;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_valid(req_valid),
    .i_ptr(r_ptr),
    .o_grant(w_grant),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  assign w_take = r_state == IDLE && w_any && !rst;
  assign w_last = r_cnt == CNTW'(NCHUNK - 1);
  assign w_chunk = {1'b0, r_a[CHUNK_W-1:0]} + {1'b0, r_b[CHUNK_W-1:0]} + (CHUNK_W + 1)'(r_carry);
  // operands shift down and results shift in from the top, so after NCHUNK steps r_acc is aligned
  assign w_acc = DATA_W'({w_chunk[CHUNK_W-1:0], r_acc} >> CHUNK_W);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_any ? ADD : IDLE) :
             r_state == ADD  ? (w_last ? RESP : ADD) :
             (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_cnt <= '0;
      r_carry <= 1'b0;
      r_sum <= '0;
      r_cout <= 1'b0;
      r_id <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_a <= req_a[w_idx*DATA_W +: DATA_W];
        r_b <= req_b[w_idx*DATA_W +: DATA_W];
        r_carry <= req_cin[w_idx];
        r_cnt <= '0;
        r_op_id <= w_idx;
        r_ptr <= w_idx == IW'(NREQ - 1) ? '0 : w_idx + 1'b1;
      end else if (r_state == ADD) begin
        r_a <= r_a >> CHUNK_W;
        r_b <= r_b >> CHUNK_W;
        r_acc <= w_acc;
        r_carry <= w_chunk[CHUNK_W];
        r_cnt <= r_cnt + 1'b1;
        // response registers only move on completion so they hold through the next ADD
        if (w_last) begin
          r_sum <= w_acc;
          r_cout <= w_chunk[CHUNK_W];
          r_id <= r_op_id;
        end
      end
    end
  end
  assign req_ready = w_take ? w_grant : '0;
  assign rsp_valid = r_state == RESP;
  assign rsp_sum = r_sum;
  assign rsp_cout = r_cout;
  assign rsp_id = r_id;
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_adder_256_sched.sv
// tb_adder_256_sched: table, hand-written and randomized checks of adder_256_sched against a plain-arithmetic model
module tb_adder_256_sched;
  localparam int DW = 256, CW = 64, NR = 2, NC = DW / CW;
  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready, req_cin = '0;
  logic [NR*DW-1:0] req_a = '0, req_b = '0;
  logic rsp_valid, rsp_ready = 1'b1, rsp_cout, busy;
  logic [DW-1:0] rsp_sum;
  logic [0:0] rsp_id;
  int checks = 0, errors = 0, mptr = 0;
  typedef struct {
    int id;
    logic [DW-1:0] a, b;
    logic cin;
    logic [DW-1:0] s;
    logic co;
  } vec_t;
  vec_t tbl[3];
  adder_256_sched #(.DATA_W(DW), .CHUNK_W(CW), .NREQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, logic [DW:0] got, logic [DW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    for (int c = 0; c < NC; c++) if ($urandom_range(0, 3) == 0) r[c*CW +: CW] = '1;
    return r;
  endfunction
  function automatic logic [DW:0] model(logic [DW-1:0] a, logic [DW-1:0] b, logic cin);
    return {1'b0, a} + {1'b0, b} + (DW + 1)'(cin);
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
  endtask
  task automatic finish_op(string n, logic [DW:0] e, int id, int stall);
    int lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({n, "_lat"}, lat, NC + 1);
    chk({n, "_sum"}, {rsp_cout, rsp_sum}, e);
    chk({n, "_id"}, rsp_id, id);
    if (stall > 0) begin
      rsp_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        chk({n, "_hold_sum"}, {rsp_cout, rsp_sum}, e);
        chk({n, "_hold_ctl"}, {rsp_valid, busy, req_ready}, {2'b11, NR'(0)});
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk({n, "_idle"}, {busy, rsp_valid}, 0);
  endtask
  task automatic op(string n, int id, logic [DW-1:0] a, logic [DW-1:0] b, logic cin,
                    logic [DW:0] e, int stall);
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
    req_cin[id] = cin;
    req_valid[id] = 1'b1;
    #1 chk({n, "_rdy"}, req_ready, NR'(1) << id);
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    mptr = (id + 1) % NR;
    finish_op(n, e, id, stall);
  endtask
  task automatic rand_op();
    logic [NR-1:0] m;
    int g;
    logic [DW:0] e;
    m = NR'($urandom_range(1, (1 << NR) - 1));
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = rnd();
      req_b[i*DW +: DW] = rnd();
      req_cin[i] = 1'($urandom);
    end
    req_valid = m;
    g = 0;
    for (int k = NR - 1; k >= 0; k--) if (m[(mptr + k) % NR]) g = (mptr + k) % NR;
    e = model(req_a[g*DW +: DW], req_b[g*DW +: DW], req_cin[g]);
    #1 chk("rnd_grant", req_ready, NR'(1) << g);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    mptr = (g + 1) % NR;
    finish_op("rnd", e, g, $urandom_range(0, 3));
  endtask
  initial begin
    int n, g, hits;
    logic [DW:0] e;
    tbl[0] = '{0, 256'hff, 256'hff, 1'b1, 256'h1ff, 1'b0};
    tbl[1] = '{1, '1, 256'h0, 1'b1, 256'h0, 1'b1};
    tbl[2] = '{0, 256'hffff_ffff_ffff_ffff, 256'h1, 1'b0, 256'h1_0000_0000_0000_0000, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {busy, rsp_valid, req_ready, rsp_cout, rsp_id, rsp_sum}, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      op($sformatf("tbl%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].co, tbl[i].s}, 0);
    // backpressure with the other requester waiting
    req_a[0 +: DW] = 256'h1234;
    req_b[0 +: DW] = 256'h4321;
    req_cin[0] = 1'b0;
    req_valid[0] = 1'b1;
    #1 chk("bp_rdy", req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    mptr = 1;
    finish_op("bp", 257'h5555, 0, 10);
    req_valid = '0;
    // round robin with both holding valid
    do_reset();
    req_a = {256'h7, 256'h5};
    req_b = {256'h9, 256'h3};
    req_cin = 2'b10;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      #1;
      while (req_ready == '0 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_onehot", $countones(req_ready), 1);
      g = req_ready[1] ? 1 : 0;
      chk("rr_order", g, i % 2);
      e = model(req_a[g*DW +: DW], req_b[g*DW +: DW], req_cin[g]);
      @(posedge clk);
      @(negedge clk);
      finish_op("rr", e, g, 0);
    end
    req_valid = '0;
    mptr = 0;
    // reset in the second ADD cycle
    req_a[0 +: DW] = '1;
    req_b[0 +: DW] = 256'h1;
    req_valid[0] = 1'b1;
    #1 chk("rst_rdy", req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    chk("rst_mid", {busy, rsp_valid, rsp_sum}, 0);
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    chk("rst_no_rsp", hits, 0);
    op("post_rst", 1, 256'hdead_beef, 256'h1_0000_0000_0000_0000, 1'b1,
       257'h1_0000_0000_dead_bef0, 0);
    for (int t = 0; t < 40; t++) rand_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
